// File: rtl/seg_conv_seq.sv
// Seconds-to-calendar sequencer: one shared restoring divider stepped through five fixed divisors.
// Latency: start accepted at edge T -> done pulse in cycle T+161, ready again at T+162.
// Backpressure: start is honoured only while ready=1; it is ignored (not queued) while busy.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, in_seg       conversion request and the seconds value captured with it
//   ready, busy, done   idle flag, conversion-in-progress flag, one-cycle result-update pulse
//   anos..segundos      calendar breakdown, held until the next done pulse
module seg_conv_seq #(
   parameter int W        = 32,
   parameter int SEG_ANO  = 31536000,
   parameter int SEG_MES  = 2592000,
   parameter int SEG_DIA  = 86400,
   parameter int SEG_HORA = 3600,
   parameter int SEG_MIN  = 60
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] in_seg,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [7:0]   anos,
   output logic [3:0]   mes,
   output logic [4:0]   dias,
   output logic [4:0]   horas,
   output logic [5:0]   minutos,
   output logic [5:0]   segundos
);

   localparam int CW = $clog2(W);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [2:0]    stage;
   logic [CW-1:0] bit_cnt;
   logic [W-1:0]  dividend;   // remainder of the previous stage, shifted out MSB first
   logic [W-1:0]  partial;
   logic [W-1:0]  quotient;

   // Quotients of the first four stages wait here so all outputs switch together.
   logic [7:0]    sh_anos;
   logic [3:0]    sh_mes;
   logic [4:0]    sh_dias;
   logic [4:0]    sh_horas;

   logic [W-1:0]  divisor;
   logic [W:0]    trial;
   logic [W:0]    diff;
   logic          take;
   logic [W-1:0]  part_next;
   logic [W-1:0]  q_next;
   logic          last_bit;

   always_comb begin
      divisor = W'(SEG_MIN);
      case (stage)
         3'd0:    divisor = W'(SEG_ANO);
         3'd1:    divisor = W'(SEG_MES);
         3'd2:    divisor = W'(SEG_DIA);
         3'd3:    divisor = W'(SEG_HORA);
         default: divisor = W'(SEG_MIN);
      endcase
   end

   // Trial subtraction one bit wider than the datapath: the top bit of the
   // difference is the borrow, so "no borrow" means partial >= divisor.
   always_comb begin
      trial     = {partial, dividend[W-1]};
      diff      = trial - {1'b0, divisor};
      take      = ~diff[W];
      part_next = take ? diff[W-1:0] : trial[W-1:0];
      q_next    = {quotient[W-2:0], take};
      last_bit  = (bit_cnt == CW'(W-1));
   end

   assign ready = (state == S_IDLE);
   assign busy  = (state == S_DIV) || (state == S_DONE);
   assign done  = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         stage    <= '0;
         bit_cnt  <= '0;
         dividend <= '0;
         partial  <= '0;
         quotient <= '0;
         sh_anos  <= '0;
         sh_mes   <= '0;
         sh_dias  <= '0;
         sh_horas <= '0;
         anos     <= '0;
         mes      <= '0;
         dias     <= '0;
         horas    <= '0;
         minutos  <= '0;
         segundos <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  dividend <= in_seg;
                  partial  <= '0;
                  quotient <= '0;
                  bit_cnt  <= '0;
                  stage    <= '0;
                  state    <= S_DIV;
               end
            end

            S_DIV: begin
               if (!last_bit) begin
                  partial  <= part_next;
                  quotient <= q_next;
                  dividend <= {dividend[W-2:0], 1'b0};
                  bit_cnt  <= bit_cnt + 1'b1;
               end else begin
                  // Stage complete: the remainder becomes the next stage's dividend.
                  partial  <= '0;
                  quotient <= '0;
                  dividend <= part_next;
                  bit_cnt  <= '0;
                  case (stage)
                     3'd0: sh_anos  <= q_next[7:0];
                     3'd1: sh_mes   <= q_next[3:0];
                     3'd2: sh_dias  <= q_next[4:0];
                     3'd3: sh_horas <= q_next[4:0];
                     default: begin
                        // Outputs land on this edge so they are valid during the done cycle.
                        anos     <= sh_anos;
                        mes      <= sh_mes;
                        dias     <= sh_dias;
                        horas    <= sh_horas;
                        minutos  <= q_next[5:0];
                        segundos <= part_next[5:0];
                     end
                  endcase
                  if (stage == 3'd4) begin
                     stage <= '0;
                     state <= S_DONE;
                  end else begin
                     stage <= stage + 1'b1;
                  end
               end
            end

            S_DONE: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_conv_seq.sv
module tb_seg_conv_seq;

   typedef struct packed {
      logic [7:0] a;
      logic [3:0] m;
      logic [4:0] d;
      logic [4:0] h;
      logic [5:0] mi;
      logic [5:0] s;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] in_seg = '0;
   logic        ready, busy, done;
   logic [7:0]  anos;
   logic [3:0]  mes;
   logic [4:0]  dias, horas;
   logic [5:0]  minutos, segundos;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   seg_conv_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_seg(in_seg),
      .ready(ready), .busy(busy), .done(done),
      .anos(anos), .mes(mes), .dias(dias), .horas(horas),
      .minutos(minutos), .segundos(segundos)
   );

   always #5 clk = ~clk;

   // Calendar breakdown straight from the cascade rule, using plain / and %.
   function automatic res_t calc(input logic [31:0] v);
      res_t r;
      longint unsigned x;
      x = v;
      r.a  = 8'(x / 31536000); x = x % 31536000;
      r.m  = 4'(x / 2592000);  x = x % 2592000;
      r.d  = 5'(x / 86400);    x = x % 86400;
      r.h  = 5'(x / 3600);     x = x % 3600;
      r.mi = 6'(x / 60);
      r.s  = 6'(x % 60);
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: cycles elapsed since acceptance (0 = idle); done in the 161st cycle.
   int   m_cnt;
   res_t m_pend, m_out;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0;
         m_out <= '0;
      end else if (m_cnt == 0) begin
         if (start) begin
            m_cnt  <= 1;
            m_pend <= calc(in_seg);
         end
      end else begin
         m_cnt <= (m_cnt == 161) ? 0 : m_cnt + 1;
         if (m_cnt == 160) m_out <= m_pend;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ready", ready, m_cnt == 0);
         chk("busy",  busy,  m_cnt != 0);
         chk("done",  done,  m_cnt == 161);
         chk("anos",  anos,  m_out.a);
         chk("mes",   mes,   m_out.m);
         chk("dias",  dias,  m_out.d);
         chk("horas", horas, m_out.h);
         chk("minutos",  minutos,  m_out.mi);
         chk("segundos", segundos, m_out.s);
      end
   end

   // Pulse start with v, wait for done, compare against hand-computed literals.
   // poke>0 pulses start with in_seg=59 at that many cycles into the conversion.
   task automatic run(input string tag, input logic [31:0] v, input res_t exp,
                      input int poke, output int busy_cyc, output int done_cyc);
      bit got;
      got = 1'b0;
      busy_cyc = 0;
      done_cyc = 0;
      @(negedge clk);
      start = 1'b1;
      in_seg = v;
      @(negedge clk);
      start = 1'b0;
      in_seg = $urandom;
      for (int i = 1; i < 300; i++) begin
         if (busy) busy_cyc++;
         if (done) begin
            done_cyc++;
            got = 1'b1;
            break;
         end
         @(negedge clk);
         start = (poke > 0 && i + 1 == poke);
         if (start) in_seg = 32'd59;
      end
      start = 1'b0;
      if (!got) begin
         failures++;
         $display("FAIL %s timeout: no done within 300 cycles", tag);
      end
      chk({tag, ".anos"}, anos, exp.a);
      chk({tag, ".mes"}, mes, exp.m);
      chk({tag, ".dias"}, dias, exp.d);
      chk({tag, ".horas"}, horas, exp.h);
      chk({tag, ".minutos"}, minutos, exp.mi);
      chk({tag, ".segundos"}, segundos, exp.s);
      @(negedge clk);
      if (done) done_cyc++;
      chk({tag, ".ready_after"}, ready, 1);
      chk({tag, ".done_after"}, done, 0);
   endtask

   initial begin
      int bc, dc, gap, n_done, last_t;
      res_t r;

      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      chk("reset.ready", ready, 1);
      chk("reset.busy", busy, 0);
      chk("reset.segundos", segundos, 0);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      r = '{a: 8'd0, m: 4'd0, d: 5'd0, h: 5'd0, mi: 6'd0, s: 6'd0};
      run("zero", 32'd0, r, 0, bc, dc);
      chk("zero.busy_cycles", bc, 161);

      r = '{a: 8'd0, m: 4'd0, d: 5'd0, h: 5'd1, mi: 6'd1, s: 6'd1};
      run("hms", 32'd3661, r, 0, bc, dc);

      r = '{a: 8'd1, m: 4'd1, d: 5'd1, h: 5'd1, mi: 6'd1, s: 6'd1};
      run("ones", 32'd34218061, r, 0, bc, dc);
      chk("ones.busy_cycles", bc, 161);
      chk("ones.done_cycles", dc, 1);

      r = '{a: 8'd0, m: 4'd12, d: 5'd4, h: 5'd23, mi: 6'd59, s: 6'd59};
      run("month12", 32'd31535999, r, 0, bc, dc);

      r = '{a: 8'd136, m: 4'd2, d: 5'd10, h: 5'd6, mi: 6'd28, s: 6'd15};
      run("max", 32'hFFFF_FFFF, r, 50, bc, dc);
      chk("max.busy_cycles", bc, 161);
      repeat (5) @(negedge clk);
      chk("max.hold_segundos", segundos, 15);
      chk("max.hold_anos", anos, 136);
      chk("max.still_idle", ready, 1);

      // Continuous start: one done every 162 cycles.
      @(negedge clk);
      start = 1'b1;
      in_seg = 32'd3661;
      n_done = 0;
      last_t = 0;
      gap = 0;
      for (int i = 0; i < 400 && n_done < 2; i++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            gap = i - last_t;
            last_t = i;
         end
      end
      start = 1'b0;
      chk("cont.dones", n_done, 2);
      chk("cont.gap", gap, 162);
      repeat (3) @(negedge clk);

      // Abort mid-conversion.
      @(negedge clk);
      start = 1'b1;
      in_seg = 32'd3661;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      repeat (79) begin
         @(negedge clk);
         if (done) n_done++;
      end
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("abort.ready", ready, 1);
      chk("abort.busy", busy, 0);
      chk("abort.horas", horas, 0);
      chk("abort.minutos", minutos, 0);
      chk("abort.segundos", segundos, 0);
      #2 rst_n = 1'b1;
      repeat (200) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("abort.no_done", n_done, 0);

      r = '{a: 8'd0, m: 4'd0, d: 5'd0, h: 5'd0, mi: 6'd0, s: 6'd59};
      run("after_abort", 32'd59, r, 0, bc, dc);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_conv_seq.md
Name: seg_conv_seq

Overview:
- Multi-cycle sequencer for the seconds-to-calendar breakdown: years, months, days, hours, minutes, seconds.
- Owns one shared 32-bit restoring divider and runs it through five fixed divisors in sequence. This replaces five parallel combinational dividers.
- Uses a start/done handshake. Sits between the input register of the conversion path and the display/formatting logic.

Parameters:
- W, 32, width of in_seg and of the divider datapath.
- SEG_ANO, 31536000, seconds per year (365 days).
- SEG_MES, 2592000, seconds per month (30 days).
- SEG_DIA, 86400, seconds per day.
- SEG_HORA, 3600, seconds per hour.
- SEG_MIN, 60, seconds per minute.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a conversion; sampled only when ready=1.
- in_seg  in  W  seconds value; captured in the cycle start is accepted.
- ready  out  1  high in IDLE only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when results update.
- anos  out  8  years (0..136).
- mes  out  4  months (0..12).
- dias  out  5  days (0..29).
- horas  out  5  hours (0..23).
- minutos  out  6  minutes (0..59).
- segundos  out  6  seconds (0..59).

Behaviour:
- Reset (rst_n=0, asynchronous): FSM goes to IDLE; ready=1; busy=0; done=0; all result outputs 0; internal dividend, remainder, quotient and counters cleared.
- FSM states and transitions:
  - IDLE: when start=1, capture in_seg into the remainder register, set stage=0, go to DIV.
  - DIV: restoring division, one quotient bit per cycle, MSB first, 32 cycles per stage. Each cycle: partial = {partial[W-2:0], dividend bit}; if partial >= divisor then subtract and set quotient bit to 1.
  - DIV, end of 32nd iteration: write the quotient to the stage's shadow register and the remainder to the dividend for the next stage. stage 0..3 → stage+1, stay in DIV. stage 4 → DONE.
  - DONE: copy shadow registers to the outputs; segundos = final remainder[5:0]; done=1 for exactly one cycle; go to IDLE.
- Stage divisors, in order: SEG_ANO, SEG_MES, SEG_DIA, SEG_HORA, SEG_MIN.
- Cascade rule: each stage divides the remainder of the previous stage, never the original in_seg.
- Width rule: quotients are truncated to their output widths. Value ranges guarantee no loss at W=32 with the default divisors.
- Months can reach 12, because 365 days = 12×30 + 5.
- Latency: start sampled at edge T → done high in cycle T+161 (5×32 DIV cycles + 1 DONE cycle). busy=1 from T+1 through T+161. ready=1 again from T+162.
- Result outputs change only in the DONE cycle and otherwise hold the last result.
- start while busy or in DONE: ignored and not queued. in_seg changes during a conversion have no effect.
- start held high continuously: a new conversion is accepted on each return to IDLE, so done pulses every 162 cycles.
- Reset mid-conversion: immediate abort, no done pulse, outputs return to 0.
- Divisors are constants: no divide-by-zero path exists.

Test Plan:
- Reset, then start with in_seg=0 → done at +161 cycles; all outputs 0; ready returns the next cycle.
- in_seg=3661 → anos=0 mes=0 dias=0 horas=1 minutos=1 segundos=1.
- in_seg=34218061 → all six outputs =1; check busy is high for exactly 161 cycles and done for exactly 1.
- in_seg=31535999 → anos=0 mes=12 dias=4 horas=23 minutos=59 segundos=59 (month boundary).
- in_seg=32'hFFFFFFFF → anos=136 mes=2 dias=10 horas=6 minutos=28 segundos=15. Pulse start again at +50 cycles with in_seg=59 → ignored; outputs unchanged.
- Start in_seg=3661, assert rst_n=0 at +80 cycles → no done pulse; outputs 0; ready=1. After release, in_seg=59 → segundos=59, all other outputs 0.
